// File: rtl/iosys_pkg.sv
// Shared constants, state encoding and helpers for the IOSYS memory arbiter.
package iosys_pkg;

    localparam logic [1:0]  REQ_BOOT      = 2'd0;
    localparam logic [1:0]  REQ_CPU       = 2'd1;
    localparam logic [1:0]  REQ_DMA       = 2'd2;
    localparam logic [1:0]  GRANT_NONE    = 2'd3;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // GRANT_NONE shifts out of range and yields no ready bit at all.
    function automatic logic [2:0] grant_onehot(input logic [1:0] g);
        return 3'b001 << g;
    endfunction

endpackage

// File: rtl/iosys_arb_pick.sv
// Winner selection: boot loader has absolute priority, CPU and DMA alternate.
module iosys_arb_pick
    import iosys_pkg::*;
(
    input  logic [2:0] req_valid_i,
    input  logic       last_dma_i,
    output logic [1:0] winner_o,
    output logic       any_o
);

    always_comb begin
        winner_o = GRANT_NONE;
        if (req_valid_i[0]) begin
            winner_o = REQ_BOOT;
        end else if (req_valid_i[1] && req_valid_i[2]) begin
            winner_o = last_dma_i ? REQ_CPU : REQ_DMA;
        end else if (req_valid_i[1]) begin
            winner_o = REQ_CPU;
        end else if (req_valid_i[2]) begin
            winner_o = REQ_DMA;
        end
        any_o = |req_valid_i;
    end

endmodule

// File: rtl/iosys_mem_arb.sv
// Three-requester memory arbiter (boot/CPU/DMA) in front of one downstream port.
// Define IOSYS_ARB_TIMEOUT_EN to add the downstream completion watchdog.
module iosys_mem_arb
    import iosys_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [95:0]           req_wdata,
    input  logic [11:0]           req_wstrb,
    output logic [2:0]            req_ready,
    output logic [31:0]           req_rdata,
    output logic                  rv_valid,
    input  logic                  rv_ready,
    output logic [ADDR_W-1:0]     rv_addr,
    output logic [31:0]           rv_wdata,
    output logic [3:0]            rv_wstrb,
    input  logic [31:0]           rv_rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_err
);

    logic [ADDR_W-1:0] addr_slice  [4];
    logic [31:0]       wdata_slice [4];
    logic [3:0]        wstrb_slice [4];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slice
            assign addr_slice[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_slice[gi] = req_wdata[gi*32 +: 32];
            assign wstrb_slice[gi] = req_wstrb[gi*4 +: 4];
        end
    endgenerate

    // Entry 3 corresponds to GRANT_NONE; it is never latched but keeps the mux total.
    assign addr_slice[3]  = '0;
    assign wdata_slice[3] = '0;
    assign wstrb_slice[3] = '0;

    state_e            state_q;
    logic [1:0]        grant_q;
    logic              last_dma_q;
    logic              rv_valid_q;
    logic [ADDR_W-1:0] rv_addr_q;
    logic [31:0]       rv_wdata_q;
    logic [3:0]        rv_wstrb_q;
    logic [31:0]       rdata_q;
    logic [2:0]        ready_q;
    logic [1:0]        pick_winner;
    logic              pick_any;

`ifdef IOSYS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             terr_q;
`endif

    iosys_arb_pick u_pick (
        .req_valid_i (req_valid),
        .last_dma_i  (last_dma_q),
        .winner_o    (pick_winner),
        .any_o       (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= GRANT_NONE;
            last_dma_q <= 1'b0;
            rv_valid_q <= 1'b0;
            rv_addr_q  <= '0;
            rv_wdata_q <= '0;
            rv_wstrb_q <= '0;
            rdata_q    <= '0;
            ready_q    <= '0;
`ifdef IOSYS_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= '0;
                    if (pick_any) begin
                        state_q    <= ST_REQ;
                        grant_q    <= pick_winner;
                        rv_valid_q <= 1'b1;
                        rv_addr_q  <= addr_slice[pick_winner];
                        rv_wdata_q <= wdata_slice[pick_winner];
                        rv_wstrb_q <= wstrb_slice[pick_winner];
                        // Boot grants leave the CPU/DMA rotation untouched.
                        if (pick_winner == REQ_CPU) begin
                            last_dma_q <= 1'b0;
                        end else if (pick_winner == REQ_DMA) begin
                            last_dma_q <= 1'b1;
                        end
`ifdef IOSYS_ARB_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (rv_ready) begin
                        state_q    <= ST_RESP;
                        rv_valid_q <= 1'b0;
                        rdata_q    <= rv_rdata;
                        ready_q    <= grant_onehot(grant_q);
                    end
`ifdef IOSYS_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q    <= ST_RESP;
                        rv_valid_q <= 1'b0;
                        rdata_q    <= TIMEOUT_RDATA;
                        ready_q    <= grant_onehot(grant_q);
                        terr_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    grant_q <= GRANT_NONE;
                    ready_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign req_rdata = rdata_q;
    assign rv_valid  = rv_valid_q;
    assign rv_addr   = rv_addr_q;
    assign rv_wdata  = rv_wdata_q;
    assign rv_wstrb  = rv_wstrb_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef IOSYS_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    // Without the watchdog TIMEOUT has no effect and the flag is constant low.
    assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_iosys_mem_arb.sv
// Randomized scoreboard bench for iosys_mem_arb against a transaction-level model.
module tb_iosys_mem_arb;
    import iosys_pkg::*;

    localparam int AW = 23;
`ifdef IOSYS_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req_valid;
    logic [3*AW-1:0]   req_addr;
    logic [95:0]       req_wdata;
    logic [11:0]       req_wstrb;
    logic [2:0]        req_ready;
    logic [31:0]       req_rdata;
    logic              rv_valid;
    logic              rv_ready;
    logic [AW-1:0]     rv_addr;
    logic [31:0]       rv_wdata;
    logic [3:0]        rv_wstrb;
    logic [31:0]       rv_rdata;
    logic [1:0]        grant;
    logic              busy;
    logic              timeout_err;

    iosys_mem_arb #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .rv_valid    (rv_valid),
        .rv_ready    (rv_ready),
        .rv_addr     (rv_addr),
        .rv_wdata    (rv_wdata),
        .rv_wstrb    (rv_wstrb),
        .rv_rdata    (rv_rdata),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } txn_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    txn_t pend [3][$];
    exp_t sb [$];
    exp_t mon_e;

    int   n_vec = 0;
    int   n_bad = 0;
    int   m_phase = 0;
    int   m_owner = 3;
    int   m_last_rr = 1;
    int   m_cnt = 0;
    bit   m_terr = 1'b0;
    txn_t m_lat;
    bit   gen_en, rst_en, silent;
    int   resp_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.addr  = a;
        t.wdata = d;
        t.wstrb = s;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [3:0] s;
        s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
        return mk_txn(AW'($urandom), $urandom, s);
    endfunction

    // Boot first; CPU/DMA contention goes to whichever of {1,2} was not served last.
    function automatic int ref_pick(input logic [2:0] v, input int last_rr);
        if (v[0]) return 0;
        if (v[1] && v[2]) return 3 - last_rr;
        return v[1] ? 1 : 2;
    endfunction

    // Reference model: runs just after each edge on the values the DUT sampled.
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (reset) begin
            m_phase   = 0;
            m_last_rr = 1;
            m_terr    = 1'b0;
            sb.delete();
            check("rst_rv_valid", rv_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_grant", grant, 3);
            check("rst_busy", busy, 0);
            check("rst_timeout_err", timeout_err, 0);
            check("rst_rv_fields", {rv_addr, rv_wdata, rv_wstrb}, 0);
            check("rst_req_rdata", req_rdata, 0);
        end else begin
            case (m_phase)
                0: begin
                    if (req_valid != 3'b000) begin
                        m_owner = ref_pick(req_valid, m_last_rr);
                        if (m_owner != 0) m_last_rr = m_owner;
                        m_lat   = pend[m_owner][0];
                        m_cnt   = 0;
                        m_phase = 1;
                        check("grant_sel", grant, m_owner);
                        check("rv_launch", {busy, rv_valid, rv_addr, rv_wdata, rv_wstrb},
                              {1'b1, 1'b1, m_lat.addr, m_lat.wdata, m_lat.wstrb});
                    end else begin
                        check("idle_outputs", {rv_valid, busy, grant}, {1'b0, 1'b0, 2'd3});
                    end
                end
                1: begin
                    m_cnt++;
                    if (rv_ready) begin
                        ex.who = 2'(m_owner);
                        ex.rdata = rv_rdata;
                        ex.chk = (m_lat.wstrb == 4'b0000);
                        sb.push_back(ex);
                        m_phase = 2;
                        check("rv_drop", {rv_valid, busy}, {1'b0, 1'b1});
                    end
`ifdef IOSYS_ARB_TIMEOUT_EN
                    else if (m_cnt == TMO) begin
                        ex.who = 2'(m_owner);
                        ex.rdata = 32'hDEADBEEF;
                        ex.chk = 1'b1;
                        sb.push_back(ex);
                        m_terr  = 1'b1;
                        m_phase = 2;
                        check("rv_drop_timeout", rv_valid, 0);
                    end
`endif
                    else begin
                        check("rv_hold", {busy, grant, rv_valid, rv_addr, rv_wdata, rv_wstrb},
                              {1'b1, 2'(m_owner), 1'b1, m_lat.addr, m_lat.wdata, m_lat.wstrb});
                    end
                end
                default: begin
                    m_phase = 0;
                    check("resp_end", {rv_valid, busy, grant}, {1'b0, 1'b0, 2'd3});
                end
            endcase
            check("timeout_err", timeout_err, m_terr);
        end
    end

    // Response monitor: every req_ready pulse must match the oldest expected response.
    always @(posedge clk) begin
        #2;
        if (!reset && (req_ready != 3'b000 || sb.size() != 0)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_unexpected: req_ready=%b, required 000 (t=%0t)", req_ready, $time);
            end else begin
                mon_e = sb.pop_front();
                check("ready_bit", req_ready, 3'b001 << mon_e.who);
                if (mon_e.chk) check("req_rdata", req_rdata, mon_e.rdata);
            end
        end
    end

    // One cycle of requester, downstream and reset stimulus, applied on the falling edge.
    task automatic drive_cycle();
        txn_t t;
        if (m_phase == 2 && pend[m_owner].size() > 0) t = pend[m_owner].pop_front();
        if (gen_en) begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i].size() < 3 && $urandom_range(0, 9) < ((i == 0) ? 1 : 3))
                    pend[i].push_back(rand_txn());
            end
        end
        for (int i = 0; i < 3; i++) begin
            t = rand_txn();
            // The owner's slice is scrambled while its access is in flight.
            if (pend[i].size() > 0 && !(m_phase == 1 && m_owner == i)) t = pend[i][0];
            req_valid[i]           = (pend[i].size() > 0);
            req_addr[i*AW +: AW]   = t.addr;
            req_wdata[i*32 +: 32]  = t.wdata;
            req_wstrb[i*4 +: 4]    = t.wstrb;
        end
        rv_ready = 1'b0;
        if (resp_wait < 0 && rv_valid && !silent) resp_wait = $urandom_range(0, 3);
        if (resp_wait == 0) begin
            rv_ready  = 1'b1;
            rv_rdata  = $urandom;
            resp_wait = -1;
        end else if (resp_wait > 0) begin
            resp_wait--;
        end else if (!rv_valid && $urandom_range(0, 7) == 0) begin
            rv_ready = 1'b1;
            rv_rdata = $urandom;
        end
        reset = rst_en && (m_phase == 1) && ($urandom_range(0, 63) == 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        gen_en = 1'b0;
        rst_en = 1'b0;
        while (k < 500 && !(pend[0].size() == 0 && pend[1].size() == 0 &&
                            pend[2].size() == 0 && m_phase == 0)) begin
            drive_cycle();
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 500) begin
            n_bad++;
            $display("FAIL drain: requests still pending after %0d cycles, required 0", k);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rv_ready = 1'b0; rv_rdata = '0;
        gen_en = 1'b0; rst_en = 1'b0; silent = 1'b0; resp_wait = -1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Boot and CPU together, then sustained CPU/DMA contention.
        pend[0].push_back(mk_txn(23'h001000, 32'hA5A5_0001, 4'b0100));
        pend[1].push_back(mk_txn(23'h000100, 32'h0, 4'b0000));
        repeat (20) begin drive_cycle(); @(negedge clk); end
        pend[1].push_back(mk_txn(23'h000104, 32'h0, 4'b0000));
        pend[1].push_back(mk_txn(23'h000108, 32'h1111_2222, 4'b1111));
        pend[2].push_back(mk_txn(23'h7F0000, 32'h3333_4444, 4'b0011));
        pend[2].push_back(mk_txn(23'h7F0004, 32'h0, 4'b0000));
        repeat (40) begin drive_cycle(); @(negedge clk); end

        gen_en = 1'b1;
        rst_en = 1'b1;
        repeat (3000) begin drive_cycle(); @(negedge clk); end
        drain();

`ifdef IOSYS_ARB_TIMEOUT_EN
        silent = 1'b1;
        pend[1].push_back(mk_txn(23'h000200, 32'h0, 4'b0000));
        repeat (40) begin drive_cycle(); @(negedge clk); end
        silent = 1'b0;
        gen_en = 1'b1;
        repeat (200) begin drive_cycle(); @(negedge clk); end
        drain();
`endif

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin drive_cycle(); @(negedge clk); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
